// File: rtl/fb_line_scheduler_pkg.sv
// Shared constants for the framebuffer line scheduler: FSM encoding, pixel width, display geometry.
package fb_line_scheduler_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int PIX_W       = 12;
    localparam int DISP_W      = 1440;
    localparam int DISP_H      = 900;
    localparam int LINE_PERIOD = 1904;

    localparam int FB_W_DEF = 360;
    localparam int FB_H_DEF = 225;
endpackage

// File: rtl/fb_line_scheduler_rd_track.sv
// fb_rd_track: RAM_LAT-deep delay line pairing each issued framebuffer read with its line-buffer column.
module fb_rd_track
    import fb_line_scheduler_pkg::*;
#(
    parameter int RAM_LAT = 1,
    parameter int LB_AW   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_issue,
    input  logic [LB_AW-1:0] i_col,
    output logic             o_we,
    output logic [LB_AW-1:0] o_col
);
    logic [RAM_LAT-1:0] r_vld;
    logic [LB_AW-1:0]   r_col [RAM_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < RAM_LAT; i++) r_col[i] <= '0;
        end else begin
            r_vld[0] <= i_issue;
            r_col[0] <= i_col;
            for (int i = 1; i < RAM_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_col[i] <= r_col[i-1];
            end
        end
    end

    assign o_we  = r_vld[RAM_LAT-1];
    assign o_col = r_col[RAM_LAT-1];
endmodule

// File: rtl/fb_line_scheduler.sv
// Framebuffer RAM sequencer: burst row fetch into a ping-pong line buffer, arbitrated pixel writes.
// Optional macro FB_DOUBLE_BUF_EN adds a front/back framebuffer selected by the RAM address MSB.
module fb_line_scheduler
    import fb_line_scheduler_pkg::*;
#(
    parameter int FB_W       = FB_W_DEF,
    parameter int FB_H       = FB_H_DEF,
    parameter int SCALE_LOG2 = 2,
    parameter int ADDR_W     = 17,
    parameter int LB_AW      = 9,
    parameter int RAM_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_line_start,
    input  logic [9:0]        i_line_y,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [PIX_W-1:0]  i_wr_data,
`ifdef FB_DOUBLE_BUF_EN
    input  logic              i_frame_start,
    input  logic              i_swap_req,
    output logic              o_fb_front,
    output logic [ADDR_W:0]   o_ram_addr,
`else
    output logic [ADDR_W-1:0] o_ram_addr,
`endif
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [PIX_W-1:0]  o_ram_wdata,
    input  logic [PIX_W-1:0]  i_ram_rdata,
    output logic              o_lb_we,
    output logic              o_lb_bank,
    output logic [LB_AW-1:0]  o_lb_addr,
    output logic [PIX_W-1:0]  o_lb_wdata,
    output logic              o_disp_bank,
    output logic              o_overrun
);
`ifdef FB_DOUBLE_BUF_EN
    localparam int RA_W = ADDR_W + 1;
`else
    localparam int RA_W = ADDR_W;
`endif

    logic [1:0]       r_state;
    logic [LB_AW-1:0] r_col;
    logic [1:0]       r_cnt;
    logic [9:0]       r_row;
    logic [9:0]       r_pend_row;
    logic             r_pend;
    logic             r_overrun;
    logic             r_disp_bank;
    logic             r_done_bank;
    logic             r_fill_bank;

    logic             r_ram_en;
    logic             r_ram_we;
    logic [RA_W-1:0]  r_ram_addr;
    logic [PIX_W-1:0] r_ram_wdata;
    logic             r_rd;
    logic [LB_AW-1:0] r_rd_col;

    logic [9:0]        w_row;
    logic              w_req;
    logic              w_busy;
    logic              w_drain_done;
    logic              w_disp_next;
    logic              w_wr_ready;
    logic              w_wr_acc;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [RA_W-1:0]   w_rd_full;
    logic [RA_W-1:0]   w_wr_full;
    logic              w_trk_we;
    logic [LB_AW-1:0]  w_trk_col;

    assign w_row = i_line_y >> SCALE_LOG2;
    assign w_req = i_line_start
                && ((i_line_y & 10'((1 << SCALE_LOG2) - 1)) == 10'd0)
                && (w_row < 10'(FB_H));

    assign w_busy       = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    assign w_drain_done = (r_state == ST_DRAIN) && (r_cnt == 2'(RAM_LAT));
    assign w_disp_next  = i_line_start ? r_done_bank : r_disp_bank;

    // A required line_start in IDLE claims the port in the same cycle, ahead of any write.
    assign w_wr_ready = (r_state != ST_FETCH) && !((r_state == ST_IDLE) && w_req) && !r_pend;
    assign w_wr_acc   = i_wr_valid && w_wr_ready;

    assign w_rd_addr = ADDR_W'(r_row) * ADDR_W'(FB_W) + ADDR_W'(r_col);

`ifdef FB_DOUBLE_BUF_EN
    logic r_fb_front;
    logic r_swap_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fb_front <= 1'b0;
            r_swap_lat <= 1'b0;
        end else begin
            r_swap_lat <= i_swap_req | (r_swap_lat & ~i_frame_start);
            if (i_frame_start && r_swap_lat) r_fb_front <= ~r_fb_front;
        end
    end

    assign o_fb_front = r_fb_front;
    assign w_rd_full  = {r_fb_front, w_rd_addr};
    assign w_wr_full  = {~r_fb_front, i_wr_addr};
`else
    assign w_rd_full = w_rd_addr;
    assign w_wr_full = i_wr_addr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_cnt       <= '0;
            r_row       <= '0;
            r_pend_row  <= '0;
            r_pend      <= 1'b0;
            r_overrun   <= 1'b0;
            r_disp_bank <= 1'b0;
            r_done_bank <= 1'b0;
            r_fill_bank <= 1'b1;
        end else begin
            if (i_line_start) r_disp_bank <= r_done_bank;

            // Single-entry request queue while a burst is in flight; a second request is lost.
            if (w_busy && w_req) begin
                if (r_pend) begin
                    r_overrun <= 1'b1;
                end else if (!w_drain_done) begin
                    r_pend     <= 1'b1;
                    r_pend_row <= w_row;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state     <= ST_FETCH;
                        r_col       <= '0;
                        r_row       <= w_row;
                        r_fill_bank <= ~w_disp_next;
                    end
                end
                ST_FETCH: begin
                    if (r_col == LB_AW'(FB_W - 1)) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= '0;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_done_bank <= r_fill_bank;
                        r_col       <= '0;
                        r_fill_bank <= ~w_disp_next;
                        if (r_pend) begin
                            r_state <= ST_FETCH;
                            r_row   <= r_pend_row;
                            r_pend  <= 1'b0;
                        end else if (w_req) begin
                            r_state <= ST_FETCH;
                            r_row   <= w_row;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_rd        <= 1'b0;
            r_rd_col    <= '0;
        end else begin
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            r_rd     <= 1'b0;
            if (r_state == ST_FETCH) begin
                r_ram_en   <= 1'b1;
                r_ram_addr <= w_rd_full;
                r_rd       <= 1'b1;
                r_rd_col   <= r_col;
            end else if (w_wr_acc) begin
                r_ram_en    <= 1'b1;
                r_ram_we    <= 1'b1;
                r_ram_addr  <= w_wr_full;
                r_ram_wdata <= i_wr_data;
            end
        end
    end

    fb_rd_track #(
        .RAM_LAT (RAM_LAT),
        .LB_AW   (LB_AW)
    ) u_rd_track (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_issue (r_rd),
        .i_col   (r_rd_col),
        .o_we    (w_trk_we),
        .o_col   (w_trk_col)
    );

    assign o_wr_ready  = w_wr_ready;
    assign o_ram_en    = r_ram_en;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;
    assign o_lb_we     = w_trk_we;
    assign o_lb_bank   = w_trk_we & r_fill_bank;
    assign o_lb_addr   = w_trk_we ? w_trk_col : '0;
    assign o_lb_wdata  = w_trk_we ? i_ram_rdata : '0;
    assign o_disp_bank = r_disp_bank;
    assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_fb_line_scheduler.sv
// Directed + randomized bench for fb_line_scheduler with a behavioural RAM and a bank/row reference model.
module tb_fb_line_scheduler;
    localparam int FB_W = 360, FB_H = 225, SCALE_LOG2 = 2, ADDR_W = 17, LB_AW = 9, RAM_LAT = 1;
`ifdef FB_DOUBLE_BUF_EN
    localparam int RA_W = ADDR_W + 1;
`else
    localparam int RA_W = ADDR_W;
`endif

    logic clk = 1'b0, rst_n = 1'b0, line_start = 1'b0;
    logic [9:0] line_y = '0;
    logic wr_valid = 1'b0, wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic ram_en, ram_we;
    logic [RA_W-1:0] ram_addr;
    logic [11:0] ram_wdata, ram_rdata = '0;
    logic lb_we, lb_bank, disp_bank, overrun;
    logic [LB_AW-1:0] lb_addr;
    logic [11:0] lb_wdata;
`ifdef FB_DOUBLE_BUF_EN
    logic frame_start = 1'b0, swap_req = 1'b0, fb_front;
`endif

    always #5 clk = ~clk;

    fb_line_scheduler #(
        .FB_W(FB_W), .FB_H(FB_H), .SCALE_LOG2(SCALE_LOG2),
        .ADDR_W(ADDR_W), .LB_AW(LB_AW), .RAM_LAT(RAM_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_line_start(line_start), .i_line_y(line_y),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data),
`ifdef FB_DOUBLE_BUF_EN
        .i_frame_start(frame_start), .i_swap_req(swap_req), .o_fb_front(fb_front),
`endif
        .o_ram_addr(ram_addr), .o_ram_en(ram_en), .o_ram_we(ram_we),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
        .o_lb_we(lb_we), .o_lb_bank(lb_bank), .o_lb_addr(lb_addr), .o_lb_wdata(lb_wdata),
        .o_disp_bank(disp_bank), .o_overrun(overrun)
    );

    function automatic logic [11:0] pix0(input int a);
        return 12'((a * 37) ^ (a >> 5) ^ 12'h5A5);
    endfunction

    // Behavioural single-port RAM, one cycle read latency; unwritten words hold pix0(addr).
    bit          wv [1 << RA_W];
    logic [11:0] wm [1 << RA_W];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                wm[ram_addr] <= ram_wdata;
                wv[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= wv[ram_addr] ? wm[ram_addr] : pix0(int'(ram_addr));
            end
        end
    end

    // Reference model state
    logic [11:0] exp_map [int];
    bit m_disp = 0, m_done = 0, m_fill = 1, m_front = 0;

    function automatic logic [11:0] exp_of(input int a);
        return exp_map.exists(a) ? exp_map[a] : pix0(a);
    endfunction
    function automatic int rd_full(input int a);
`ifdef FB_DOUBLE_BUF_EN
        return (int'(m_front) << ADDR_W) | a;
`else
        return a;
`endif
    endfunction
    function automatic int wr_full(input int a);
`ifdef FB_DOUBLE_BUF_EN
        return (int'(!m_front) << ADDR_W) | a;
`else
        return a;
`endif
    endfunction
    function automatic bit mdl_line(input int y);
        bit req;
        m_disp = m_done;
        req = ((y % (1 << SCALE_LOG2)) == 0) && ((y >> SCALE_LOG2) < FB_H);
        if (req) m_fill = !m_disp;
        return req;
    endfunction

    // Monitor
    int cyc = 0;
    int rd_a[$], rd_c[$];
    logic [11:0] lb_sh [2][512];
    int lb_cnt [2];
    initial forever begin
        @(negedge clk);
        cyc++;
        if (ram_en && !ram_we) begin
            rd_a.push_back(int'(ram_addr));
            rd_c.push_back(cyc);
        end
        if (lb_we) begin
            lb_sh[lb_bank][lb_addr] = lb_wdata;
            lb_cnt[lb_bank]++;
        end
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rd_a.delete();
        rd_c.delete();
        lb_cnt[0] = 0;
        lb_cnt[1] = 0;
    endtask

    task automatic line_pulse(input int y);
        @(posedge clk); #1;
        line_start = 1'b1;
        line_y = 10'(y);
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    task automatic verify_reads(input int idx0, input int row);
        int bad = 0;
        for (int c = 0; c < FB_W; c++) begin
            if (idx0 + c >= rd_a.size()) bad++;
            else if (rd_a[idx0+c] != rd_full(row * FB_W + c) || rd_c[idx0+c] != rd_c[idx0] + c) bad++;
        end
        chk($sformatf("rdseq_row%0d", row), bad, 0);
    endtask

    task automatic verify_lb(input int row, input bit bank);
        int bad = 0;
        for (int c = 0; c < FB_W; c++)
            if (lb_sh[bank][c] !== exp_of(rd_full(row * FB_W + c))) bad++;
        chk($sformatf("lbdata_row%0d_bank%0d", row, bank), bad, 0);
    endtask

    task automatic fetch_check(input int y);
        bit req;
        int row;
        clr();
        req = mdl_line(y);
        row = y >> SCALE_LOG2;
        line_pulse(y);
        chk($sformatf("disp_bank_y%0d", y), disp_bank, m_disp);
        repeat (FB_W + RAM_LAT + 20) @(posedge clk);
        #1;
        if (req) begin
            chk($sformatf("rd_count_y%0d", y), rd_a.size(), FB_W);
            verify_reads(0, row);
            chk($sformatf("lb_count_y%0d", y), lb_cnt[m_fill], FB_W);
            verify_lb(row, m_fill);
            m_done = m_fill;
        end else begin
            chk($sformatf("no_rd_y%0d", y), rd_a.size(), 0);
            chk($sformatf("no_lb_y%0d", y), lb_cnt[0] + lb_cnt[1], 0);
        end
        chk($sformatf("idle_ready_y%0d", y), wr_ready, 1);
    endtask

    // Leaves wr_valid high until accepted; returns the number of stalled cycles.
    task automatic do_write(input int a, input logic [11:0] d, input int limit, output int stall);
        bit acc = 0;
        bit rdy;
        stall = 0;
        wr_valid = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        for (int i = 0; i < limit && !acc; i++) begin
            @(negedge clk);
            rdy = wr_ready;
            @(posedge clk); #1;
            line_start = 1'b0;
            if (rdy) acc = 1;
            else stall++;
        end
        wr_valid = 1'b0;
        chk("wr_accept", acc, 1);
        chk("wr_ram_en_we", {ram_en, ram_we}, 2'b11);
        chk("wr_ram_addr", ram_addr, wr_full(a));
        chk("wr_ram_data", ram_wdata, d);
        exp_map[wr_full(a)] = d;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int stall, f3, r;
        bit req;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_lb_we", lb_we, 0);
        chk("rst_lb_bank", lb_bank, 0);
        chk("rst_disp_bank", disp_bank, 0);
        chk("rst_overrun", overrun, 0);

        fetch_check(0);
        fetch_check(1);
        fetch_check(2);
        fetch_check(3);
        fetch_check(4);

        // Write held across a fetch: stalled for the line_start cycle plus every FETCH cycle.
        clr();
        req = mdl_line(8);
        @(posedge clk); #1;
        line_start = 1'b1;
        line_y = 10'd8;
        do_write(500, 12'hF0A, 1000, stall);
        chk("wr_stall_cycles", stall, FB_W + 1);
        chk("wr_after_all_reads", rd_a.size(), FB_W);
        repeat (20) @(posedge clk);
        #1;
        verify_reads(0, 2);
        verify_lb(2, m_fill);
        m_done = m_fill;

        // Burst plus two more requests: one pending, one lost.
        clr();
        req = mdl_line(12);
        line_pulse(12);
        f3 = m_fill;
        repeat (50) @(posedge clk);
        req = mdl_line(16);
        line_pulse(16);
        chk("overrun_after_pending", overrun, 0);
        repeat (50) @(posedge clk);
        req = mdl_line(20);
        line_pulse(20);
        chk("overrun_set", overrun, 1);
        do_write(7, 12'h3C3, 2000, stall);
        chk("pend_blocks_write", rd_a.size(), 2 * FB_W);
        repeat (10) @(posedge clk);
        #1;
        verify_reads(0, 3);
        verify_reads(FB_W, 4);
        chk("pend_gap", rd_c[FB_W] - rd_c[FB_W-1], RAM_LAT + 2);
        chk("pend_lb_total", lb_cnt[0] + lb_cnt[1], 2 * FB_W);
        verify_lb(4, m_fill);
        m_done = m_fill;
        chk("overrun_sticky", overrun, 1);

        fetch_check(900);
        fetch_check(896);
        fetch_check(4);

        for (int it = 0; it < 5; it++) begin
            for (int w = 0; w < 3; w++)
                do_write(int'($urandom_range(0, 11 * FB_W - 1)), 12'($urandom), 20, stall);
            r = int'($urandom_range(0, 10));
            fetch_check(r * 4);
            fetch_check(r * 4 + int'($urandom_range(1, 3)));
        end

        // Reset in the middle of a burst.
        line_pulse(0);
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ram_en", ram_en, 0);
        chk("midrst_lb_we", lb_we, 0);
        chk("midrst_disp", disp_bank, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_wr_ready", wr_ready, 1);
        m_disp = 0;
        m_done = 0;
        m_fill = 1;
        @(posedge clk); #1 rst_n = 1'b1;
        fetch_check(0);
        fetch_check(5);

`ifdef FB_DOUBLE_BUF_EN
        chk("front_reset", fb_front, 0);
        @(posedge clk); #1 swap_req = 1'b1;
        @(posedge clk); #1 swap_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("front_wait_frame", fb_front, 0);
        frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        chk("front_swapped", fb_front, 1);
        m_front = 1;
        do_write(100, 12'h123, 20, stall);
        fetch_check(0);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/fb_line_scheduler.md
Name: fb_line_scheduler

Overview:
- Sequences the single-port framebuffer RAM feeding the 1440x900 VGA output.
- Each time the display advances to a new framebuffer row, it fetches that row as a burst into a ping-pong line buffer and tells the display which bank to read.
- Game-logic pixel writes share the RAM port through a valid/ready handshake; the line fetch has priority.
- Sits between the game logic, the framebuffer BRAM, the line buffer and the VGA timing block.

Parameters:
- FB_W, 360, framebuffer width in words (one 12-bit RGB pixel per word).
- FB_H, 225, framebuffer height in rows.
- SCALE_LOG2, 2, display lines per framebuffer row = 2^SCALE_LOG2.
- ADDR_W, 17, framebuffer address width.
- LB_AW, 9, line-buffer address width.
- RAM_LAT, 1, framebuffer read latency in cycles (1..3).

Ports:
- clk  in  1  pixel clock, 106.47 MHz
- rst_n  in  1  asynchronous active-low reset
- line_start  in  1  one-cycle pulse at hcount==0 of every line
- line_y  in  10  display line to be shown next (0..899); valid with line_start
- wr_valid  in  1  game-logic write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  ADDR_W  write address
- wr_data  in  12  write pixel {r,g,b}
- ram_en  out  1  RAM enable (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_wdata  out  12  RAM write data (registered)
- ram_rdata  in  12  RAM read data, valid RAM_LAT cycles after a read is issued
- lb_we  out  1  line-buffer write strobe
- lb_bank  out  1  bank being written
- lb_addr  out  LB_AW  line-buffer column
- lb_wdata  out  12  line-buffer data
- disp_bank  out  1  bank the display reads for the current line
- overrun  out  1  sticky: a fetch request was lost

Behaviour:
- Reset values:
  - state IDLE
  - all outputs 0 except wr_ready, which follows the wr_ready rule below
  - disp_bank=0, fill bank=1
  - pending=0, overrun=0
  - row register cleared
- Fetch trigger:
  - On line_start, let row = line_y >> SCALE_LOG2.
  - A fetch is required when line_y[SCALE_LOG2-1:0]==0 and row < FB_H.
  - Otherwise the line buffer is reused and no fetch starts.
- Bank swap:
  - On every line_start, disp_bank <= bank of the last completed fetch.
  - The new fetch then fills ~disp_bank, computed from the updated value.
- States:
  - IDLE: a required fetch goes to FETCH with col=0 on the line_start cycle.
  - FETCH: issues one read per cycle with ram_addr = row*FB_W + col, ram_we=0. Moves to DRAIN after col==FB_W-1 is issued.
  - DRAIN: waits RAM_LAT cycles for the final reads to return, marks the fill bank completed, then returns to IDLE, or to FETCH if pending.
- Read return:
  - A valid shift register of depth RAM_LAT tracks issued reads.
  - On each return: lb_we=1, lb_addr=col delayed RAM_LAT cycles, lb_wdata=ram_rdata.
- Write arbitration:
  - wr_ready = (state != FETCH) && !(state==IDLE && line_start && a fetch is required) && !pending.
  - An accepted write drives ram_en=1, ram_we=1, ram_addr, ram_wdata on the next cycle.
  - Writes are allowed during DRAIN.
- Simultaneous events:
  - line_start together with wr_valid in IDLE: the fetch wins and the write waits.
- Line_start while busy:
  - A required line_start in FETCH/DRAIN sets pending (depth 1, stores row).
  - A further required line_start while pending=1 sets overrun and is dropped.
  - overrun clears only on reset.
- Timing budget: a fetch takes FB_W+RAM_LAT+1 cycles, far below the 1904-cycle line period.
- Width rules:
  - row*FB_W is computed at ADDR_W bits (constant multiply).
  - col is an LB_AW-bit counter with no wrap past FB_W-1.
- Reset mid-burst: all activity aborts immediately; partially filled line-buffer contents are undefined and no bank swap occurs.

Optional Feature:
- Macro: FB_DOUBLE_BUF_EN.
- When defined:
  - Adds ports frame_start (in, 1), swap_req (in, 1) and fb_front (out, 1, reset 0).
  - RAM address widens to ADDR_W+1, with the MSB selecting the buffer.
  - Fetches read buffer fb_front; writes go to ~fb_front.
  - A swap_req pulse is latched; on the next frame_start, fb_front toggles and the latch clears.
- When undefined: single buffer, none of these ports exist, and the address width is ADDR_W.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/FETCH/DRAIN)
  - the pixel word width constant (12)
  - display geometry constants (1440, 900, 1904)
  - FB_W/FB_H defaults
- One sub-module: fb_rd_track, the RAM_LAT-deep valid/column delay line producing lb_we/lb_addr.

Test Plan:
- Reset, then line_start with line_y=0 → reads addr 0..359 on consecutive cycles; lb_we for cols 0..359 with lb_bank=1; state back to IDLE after 360+RAM_LAT+1 cycles.
- line_start with line_y=1, 2, 3 → no RAM reads; disp_bank=1 from the line_y=1 pulse onward.
- line_y=4 → reads addr 360..719 into bank 0.
- wr_valid held during a FETCH → wr_ready=0 throughout FETCH; write to addr 500 data 0xF0A issues in the DRAIN cycle with ram_we=1.
- Three required line_start pulses inside one burst → first is pending, second sets overrun=1; the pending fetch starts immediately after DRAIN.
- line_y=900 (row 225) → no fetch issued.
- With FB_DOUBLE_BUF_EN: swap_req then frame_start → fb_front=1; fetch addresses carry MSB=1 and writes carry MSB=0.
